acc_sequencer: RTL and testbench

- Program sequencer for the accumulator datapath (3-bit-opcode ALU feeding an 8-bit accumulator with clock enable).
- Fetches 12-bit instructions from a synchronous program ROM.
- Drives the ALU operation code, the B operand and the accumulator enable, and resolves conditional jumps on a registered copy of the ALU carry.
- Sits between program memory and the operation block; it is the top-level control of the microprocessor core.

---
 rtl/acc_sequencer.sv | 102 ++++++++++
 tb/tb_acc_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Program sequencer for the accumulator core: fetches 12-bit instructions from a
// synchronous ROM, drives the ALU op/operand/enable and resolves carry jumps.
module acc_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [11:0]         prog_data,
    output logic [2:0]          operation_code,
    output logic [7:0]          in_b,
    output logic                aku_enable,
    input  logic                carry_in,
    output logic                carry_q,
    output logic                busy,
    output logic                halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

    logic [2:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic [11:0]         instr_reg;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] exec_pc;
    logic                is_alu;
    logic                is_halt;
    logic                take_jump;

    always_comb begin
        pc_inc      = pc + PC_WIDTH'(1);
        // Width cast zero-extends or truncates the 8-bit operand to the PC width.
        jump_target = PC_WIDTH'(instr_reg[7:0]);
        is_alu      = ~instr_reg[11];
        is_halt     = (instr_reg[11:8] == 4'hF);
        case (instr_reg[11:8])
            4'h8:    take_jump = 1'b1;
            4'h9:    take_jump = carry_q;
            4'hA:    take_jump = ~carry_q;
            default: take_jump = 1'b0;
        endcase
        exec_pc = take_jump ? jump_target : pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= PC_INIT;
            instr_reg <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    instr_reg <= prog_data;
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state <= S_HALTED;
                    end else begin
                        pc    <= exec_pc;
                        state <= S_FETCH;
                        if (is_alu) carry_q <= carry_in;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        pc      <= PC_INIT;
                        carry_q <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enable is decoded from state so an asynchronous reset drops it immediately.
    assign aku_enable     = (state == S_EXEC) && is_alu;
    assign prog_addr      = pc;
    assign operation_code = instr_reg[10:8];
    assign in_b           = instr_reg[7:0];
    assign busy           = (state == S_FETCH) || (state == S_LOAD) || (state == S_EXEC);
    assign halted         = (state == S_HALTED);

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed programs plus random ROM images,
// compared against an instruction-level interpreter of the program.
module tb_acc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  prog_addr;
    logic [11:0] prog_data;
    logic [2:0]  operation_code;
    logic [7:0]  in_b;
    logic        aku_enable;
    logic        carry_in;
    logic        carry_q;
    logic        busy;
    logic        halted;
    logic        carry_flip;

    logic        start4;
    logic [3:0]  prog_addr4;
    logic [2:0]  operation_code4;
    logic [7:0]  in_b4;
    logic        aku_enable4;
    logic        carry_q4;
    logic        busy4;
    logic        halted4;

    logic [11:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    // Stand-in ALU carry: a fixed function of the ALU inputs, optionally inverted.
    assign carry_in = (^{operation_code, in_b}) ^ carry_flip;

    acc_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
        .operation_code(operation_code), .in_b(in_b), .aku_enable(aku_enable),
        .carry_in(carry_in), .carry_q(carry_q), .busy(busy), .halted(halted)
    );

    acc_sequencer #(.PC_WIDTH(4), .RESET_PC(0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .prog_addr(prog_addr4), .prog_data(12'hB00),
        .operation_code(operation_code4), .in_b(in_b4), .aku_enable(aku_enable4),
        .carry_in(1'b0), .carry_q(carry_q4), .busy(busy4), .halted(halted4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Interpreter results
    int exp_pc[$];
    int exp_cq[$];
    int exp_op[$];
    int exp_b[$];
    bit exp_alu[$];
    int fin_pc;
    int fin_c;
    bit halted_m;

    task automatic model(input int max_instr);
        int pc;
        int c;
        int cls;
        logic [11:0] ins;
        pc = 0;
        c  = 0;
        halted_m = 1'b0;
        exp_pc.delete(); exp_cq.delete(); exp_op.delete(); exp_b.delete(); exp_alu.delete();
        for (int i = 0; i < max_instr; i++) begin
            ins = rom[pc];
            cls = int'(ins[11:8]);
            exp_pc.push_back(pc);
            exp_cq.push_back(c);
            exp_op.push_back(int'(ins[10:8]));
            exp_b.push_back(int'(ins[7:0]));
            exp_alu.push_back(cls < 8);
            if (cls < 8) begin
                c  = int'((^ins[10:0]) ^ carry_flip);
                pc = (pc + 1) % 256;
            end else if (cls == 8) begin
                pc = int'(ins[7:0]);
            end else if (cls == 9) begin
                pc = (c == 1) ? int'(ins[7:0]) : (pc + 1) % 256;
            end else if (cls == 10) begin
                pc = (c == 0) ? int'(ins[7:0]) : (pc + 1) % 256;
            end else if (cls == 15) begin
                halted_m = 1'b1;
                break;
            end else begin
                pc = (pc + 1) % 256;
            end
        end
        fin_pc = pc;
        fin_c  = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
        rst    = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) rom[i] = 12'hB00;
    endtask

    // Starts from IDLE or HALTED (both begin at pc 0, carry 0) at a negedge.
    task automatic run_program(input int max_instr, input bit hold_start);
        model(max_instr);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int i = 0; i < exp_pc.size(); i++) begin
            check("fetch_busy", busy, 1);
            check("fetch_addr", prog_addr, exp_pc[i]);
            check("fetch_carry", carry_q, exp_cq[i]);
            @(negedge clk);
            check("load_en", aku_enable, 0);
            @(negedge clk);
            check("exec_en", aku_enable, exp_alu[i]);
            if (exp_alu[i]) begin
                check("exec_op", operation_code, exp_op[i]);
                check("exec_b", in_b, exp_b[i]);
            end
            @(negedge clk);
        end
        if (halted_m) begin
            check("halt_flag", halted, 1);
            check("halt_busy", busy, 0);
            check("halt_pc", prog_addr, fin_pc);
            check("halt_carry", carry_q, fin_c);
            if (hold_start) begin
                @(negedge clk);
                check("restart_busy", busy, 1);
                check("restart_pc", prog_addr, 0);
                check("restart_carry", carry_q, 0);
                check("restart_halted", halted, 0);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        bit any_en4;
        int k;
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        carry_flip = 1'b0;
        fill_nop();
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", prog_addr, 0);
        check("rst_carry", carry_q, 0);
        check("rst_en", aku_enable, 0);
        check("rst_op", operation_code, 0);
        check("rst_b", in_b, 0);

        // single ALU op then HALT
        rom[0] = 12'h60A;
        rom[1] = 12'hF00;
        run_program(10, 1'b0);
        check("t1_halted", halted_m, 1);

        // JC taken with carry 1, then JC not taken / JNC taken with carry 0
        fill_nop();
        rom[0] = 12'h0FF;
        rom[1] = 12'h905;
        rom[5] = 12'hF00;
        rom[2] = 12'hA07;
        rom[7] = 12'hF00;
        carry_flip = 1'b1;
        run_program(10, 1'b0);
        check("jc_taken_pc", fin_pc, 5);
        carry_flip = 1'b0;
        run_program(10, 1'b0);
        check("jnc_taken_pc", fin_pc, 7);

        // jump to 255 then wrap to 0
        fill_nop();
        rom[0] = 12'h8FF;
        run_program(4, 1'b0);
        do_reset();

        // HALT with start held high restarts immediately
        fill_nop();
        rom[0] = 12'h1F3;
        rom[1] = 12'hF00;
        carry_flip = 1'b1;
        run_program(5, 1'b1);
        do_reset();

        // async reset during EXEC of an ALU instruction
        fill_nop();
        rom[0] = 12'h0FF;
        rom[1] = 12'h3C5;
        carry_flip = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_carry_before", carry_q, 1);
        @(negedge clk);
        @(negedge clk);
        check("mid_exec_en", aku_enable, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_en", aku_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pc", prog_addr, 0);
        check("mid_rst_carry", carry_q, 0);
        check("mid_rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", busy, 0);

        // 4-bit PC over a NOP-filled ROM
        do_reset();
        any_en4 = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            check("pc4_addr", prog_addr4, i % 16);
            for (int j = 0; j < 3; j++) begin
                any_en4 |= aku_enable4;
                @(negedge clk);
            end
        end
        check("pc4_no_enable", any_en4, 0);
        do_reset();

        // random ROM images
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 256; i++) begin
                k = $urandom_range(0, 99);
                if (k < 50)      rom[i] = {1'b0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
                else if (k < 60) rom[i] = {4'h8, 8'($urandom_range(0, 255))};
                else if (k < 70) rom[i] = {4'h9, 8'($urandom_range(0, 255))};
                else if (k < 80) rom[i] = {4'hA, 8'($urandom_range(0, 255))};
                else if (k < 88) rom[i] = {4'($urandom_range(11, 14)), 8'($urandom_range(0, 255))};
                else             rom[i] = {4'hF, 8'($urandom_range(0, 255))};
            end
            carry_flip = 1'($urandom_range(0, 1));
            run_program(60, 1'b0);
            if (!halted_m) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
